// File: rtl/alu_mul_sequencer_pkg.sv
// Shared constants for the shift-and-add multiply sequencer: ALU action codes and FSM state encoding.
package alu_mul_sequencer_pkg;

   localparam int unsigned MUL_WORD_SIZE   = 16;
   localparam int unsigned MUL_ACTION_BITS = 4;
   localparam int unsigned MUL_STATE_BITS  = 3;

   // ALUAction codes understood by the shared EX-stage ALU
   localparam logic [MUL_ACTION_BITS-1:0] ALU_ADD  = 4'd0;
   localparam logic [MUL_ACTION_BITS-1:0] ALU_SHL  = 4'd6;
   localparam logic [MUL_ACTION_BITS-1:0] ALU_SHR  = 4'd7;
   localparam logic [MUL_ACTION_BITS-1:0] ALU_PASS = 4'd9;

   localparam logic [MUL_STATE_BITS-1:0] MUL_IDLE = 3'd0;
   localparam logic [MUL_STATE_BITS-1:0] MUL_ADD  = 3'd1;
   localparam logic [MUL_STATE_BITS-1:0] MUL_SHL  = 3'd2;
   localparam logic [MUL_STATE_BITS-1:0] MUL_SHR  = 3'd3;
   localparam logic [MUL_STATE_BITS-1:0] MUL_DONE = 3'd4;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-and-add multiplier that borrows the shared combinational ALU while busy;
// produces the low WORD_SIZE bits of op_a*op_b (valid for signed and unsigned operands).
module alu_mul_sequencer
   import alu_mul_sequencer_pkg::*;
#(
   parameter int unsigned WORD_SIZE       = MUL_WORD_SIZE,
   parameter int unsigned ALU_ACTION_BITS = MUL_ACTION_BITS
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [WORD_SIZE-1:0]       op_a,
   input  logic [WORD_SIZE-1:0]       op_b,
   output logic                       busy,
   output logic                       done,
   output logic [WORD_SIZE-1:0]       product,
   output logic [ALU_ACTION_BITS-1:0] alu_action,
   output logic [WORD_SIZE-1:0]       alu_a,
   output logic [WORD_SIZE-1:0]       alu_b,
   input  logic [WORD_SIZE-1:0]       alu_result
);

   localparam int unsigned CNT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

   logic [MUL_STATE_BITS-1:0] state_q, state_d;
   logic [WORD_SIZE-1:0]      acc_q, acc_d;
   logic [WORD_SIZE-1:0]      mcand_q, mcand_d;
   logic [WORD_SIZE-1:0]      mult_q, mult_d;
   logic [WORD_SIZE-1:0]      product_q, product_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= MUL_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mult_q    <= '0;
         product_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mult_q    <= mult_d;
         product_q <= product_d;
         cnt_q     <= cnt_d;
      end
   end

   // Next-state and datapath register updates; ALU results are consumed only in the state that requested them
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mult_d    = mult_q;
      product_d = product_q;
      cnt_d     = cnt_q;
      case (state_q)
         MUL_IDLE: begin
            if (start) begin
               acc_d   = '0;
               mcand_d = op_a;
               mult_d  = op_b;
               cnt_d   = '0;
               if (op_b == '0)   state_d = MUL_DONE;
               else if (op_b[0]) state_d = MUL_ADD;
               else              state_d = MUL_SHL;
            end
         end
         MUL_ADD: begin
            acc_d   = alu_result;
            state_d = MUL_SHL;
         end
         MUL_SHL: begin
            mcand_d = alu_result;
            state_d = MUL_SHR;
         end
         MUL_SHR: begin
            mult_d = alu_result;
            cnt_d  = cnt_q + CNT_W'(1);
            // the counter guard bounds the walk even if the multiplier never reaches zero
            if (alu_result == '0 || cnt_q == CNT_W'(WORD_SIZE - 1)) state_d = MUL_DONE;
            else if (alu_result[0])                               state_d = MUL_ADD;
            else                                                  state_d = MUL_SHL;
         end
         MUL_DONE: begin
            product_d = acc_q;
            state_d   = MUL_IDLE;
         end
         default: state_d = MUL_IDLE;
      endcase
   end

   // ALU request decoded purely from state
   always_comb begin
      alu_action = ALU_ACTION_BITS'(ALU_PASS);
      alu_a      = '0;
      alu_b      = '0;
      case (state_q)
         MUL_ADD: begin
            alu_action = ALU_ACTION_BITS'(ALU_ADD);
            alu_a      = acc_q;
            alu_b      = mcand_q;
         end
         MUL_SHL: begin
            alu_action = ALU_ACTION_BITS'(ALU_SHL);
            alu_a      = mcand_q;
         end
         MUL_SHR: begin
            alu_action = ALU_ACTION_BITS'(ALU_SHR);
            alu_a      = mult_q;
         end
         default: begin
            alu_action = ALU_ACTION_BITS'(ALU_PASS);
         end
      endcase
   end

   assign busy    = (state_q != MUL_IDLE);
   assign done    = (state_q == MUL_DONE);
   // product bypasses to acc during DONE so it is valid alongside the done pulse
   assign product = done ? acc_q : product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer with a behavioural model of the shared ALU and a product scoreboard.
module tb_alu_mul_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [3:0]  alu_action;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_result;

   int checks = 0;
   int errors = 0;
   logic [15:0] sb_q[$];

   alu_mul_sequencer #(.WORD_SIZE(16), .ALU_ACTION_BITS(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .op_a       (op_a),
      .op_b       (op_b),
      .busy       (busy),
      .done       (done),
      .product    (product),
      .alu_action (alu_action),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared combinational ALU stand-in
   always_comb begin
      case (alu_action)
         4'd0:    alu_result = alu_a + alu_b;
         4'd6:    alu_result = alu_a << 1;
         4'd7:    alu_result = alu_a >> 1;
         4'd9:    alu_result = alu_a;
         default: alu_result = 16'h0000;
      endcase
   end

   // Runs one multiply with an independently built per-cycle ALU trace; returns observed latency and product
   task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                          output int lat, output logic [15:0] prod);
      logic [3:0]  ta[$];
      logic [15:0] tva[$];
      logic [15:0] tvb[$];
      logic [15:0] acc, mc, mu, exp_p;
      int cnt;
      int st;
      acc = 16'h0; mc = a; mu = b; cnt = 0;
      if (b == 16'h0) st = 3;
      else st = b[0] ? 0 : 1;
      while (st != 3) begin
         case (st)
            0: begin ta.push_back(4'd0); tva.push_back(acc); tvb.push_back(mc); acc = acc + mc; st = 1; end
            1: begin ta.push_back(4'd6); tva.push_back(mc); tvb.push_back(16'h0); mc = mc << 1; st = 2; end
            default: begin
               ta.push_back(4'd7); tva.push_back(mu); tvb.push_back(16'h0);
               mu = mu >> 1;
               if (mu == 16'h0 || cnt == 15) st = 3;
               else st = mu[0] ? 0 : 1;
               cnt++;
            end
         endcase
      end
      ta.push_back(4'd9); tva.push_back(16'h0); tvb.push_back(16'h0);
      lat = -1;
      prod = 16'hxxxx;
      exp_p = a * b;
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b;
      sb_q.push_back(exp_p);
      @(posedge clk);
      #1 start = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom);
      for (int k = 0; k < ta.size(); k++) begin
         @(negedge clk);
         checks++;
         if (alu_action !== ta[k] || alu_a !== tva[k] || alu_b !== tvb[k]) begin
            errors++;
            $display("FAIL alu_decode a=%h b=%h cyc=%0d: got act=%0d a=%h b=%h, want act=%0d a=%h b=%h",
                     a, b, k + 1, alu_action, alu_a, alu_b, ta[k], tva[k], tvb[k]);
         end
         checks++;
         if (busy !== 1'b1 || done !== (k == ta.size() - 1)) begin
            errors++;
            $display("FAIL busy_done a=%h b=%h cyc=%0d: got busy=%b done=%b, want busy=1 done=%b",
                     a, b, k + 1, busy, done, (k == ta.size() - 1));
         end
         if (done === 1'b1 && lat < 0) begin
            lat = k + 1;
            prod = product;
         end
      end
      if (sb_q.size() != 0) exp_p = sb_q.pop_front();
      checks++;
      if (prod !== exp_p) begin
         errors++;
         $display("FAIL product a=%h b=%h: got %h, want %h", a, b, prod, exp_p);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== exp_p) begin
         errors++;
         $display("FAIL idle_hold a=%h b=%h: got busy=%b done=%b product=%h, want 0 0 %h",
                  a, b, busy, done, product, exp_p);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; op_a = 16'h0; op_b = 16'h0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0 ||
          alu_action !== 4'd9 || alu_a !== 16'h0 || alu_b !== 16'h0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b product=%h act=%0d a=%h b=%h, want 0 0 0000 9 0000 0000",
                  busy, done, product, alu_action, alu_a, alu_b);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat; logic [15:0] p;
      run_mul(16'd3, 16'd5, lat, p);
      checks++;
      if (lat !== 9 || p !== 16'd15) begin
         errors++;
         $display("FAIL basic_3x5: got latency=%0d product=%h, want 9 000f", lat, p);
      end
   endtask

   task automatic test_signed();
      int lat; logic [15:0] p;
      run_mul(16'hFFFD, 16'd7, lat, p);
      checks++;
      if (p !== 16'hFFEB) begin
         errors++;
         $display("FAIL signed_m3x7: got %h, want ffeb", p);
      end
   endtask

   task automatic test_boundaries();
      int lat; logic [15:0] p;
      run_mul(16'd2, 16'hFFFF, lat, p);
      checks++;
      if (lat !== 49 || p !== 16'hFFFE) begin
         errors++;
         $display("FAIL max_mult: got latency=%0d product=%h, want 49 fffe", lat, p);
      end
      run_mul(16'h1234, 16'h0000, lat, p);
      checks++;
      if (lat !== 1 || p !== 16'h0) begin
         errors++;
         $display("FAIL zero_mult: got latency=%0d product=%h, want 1 0000", lat, p);
      end
      run_mul(16'h0100, 16'h0100, lat, p);
      checks++;
      if (lat !== 20 || p !== 16'h0) begin
         errors++;
         $display("FAIL sparse_0100: got latency=%0d product=%h, want 20 0000", lat, p);
      end
      run_mul(16'h0000, 16'h00A5, lat, p);
      checks++;
      if (lat !== 21 || p !== 16'h0) begin
         errors++;
         $display("FAIL zero_mcand: got latency=%0d product=%h, want 21 0000", lat, p);
      end
   endtask

   task automatic test_random();
      int lat; logic [15:0] p;
      for (int i = 0; i < 6; i++) begin
         run_mul(16'($urandom), 16'($urandom), lat, p);
      end
   endtask

   task automatic test_back_to_back();
      int cyc = 0;
      int ndone = 0;
      int done_at[2];
      logic [15:0] exp_p;
      done_at[0] = -1; done_at[1] = -1;
      @(negedge clk);
      start = 1'b1; op_a = 16'd3; op_b = 16'd5;
      sb_q.push_back(16'd15);
      @(posedge clk);
      #1 op_a = 16'd7; op_b = 16'd9;
      sb_q.push_back(16'd63);
      while (ndone < 2 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) begin
            exp_p = (sb_q.size() != 0) ? sb_q.pop_front() : 16'hxxxx;
            checks++;
            if (product !== exp_p) begin
               errors++;
               $display("FAIL b2b_product%0d: got %h, want %h", ndone, product, exp_p);
            end
            done_at[ndone] = cyc;
            ndone++;
            if (ndone == 2) start = 1'b0;
         end
      end
      start = 1'b0;
      checks++;
      if (done_at[0] != 9 || done_at[1] != 21) begin
         errors++;
         $display("FAIL b2b_timing: got done at %0d,%0d, want 9,21", done_at[0], done_at[1]);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || product !== 16'd63) begin
         errors++;
         $display("FAIL b2b_idle: got busy=%b product=%h, want 0 003f", busy, product);
      end
   endtask

   task automatic test_reset_mid_op();
      int bad = 0;
      @(negedge clk);
      start = 1'b1; op_a = 16'd3; op_b = 16'd5;
      @(posedge clk);
      #1 start = 1'b0;
      #1;
      checks++;
      if (alu_action !== 4'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midop_in_add: got act=%0d busy=%b, want 0 1", alu_action, busy);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0) begin
         errors++;
         $display("FAIL midop_async_reset: got busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL midop_no_done: got %0d cycles with busy/done set, want 0", bad);
      end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; op_a = 16'h0; op_b = 16'h0;
      test_reset();
      test_basic();
      test_signed();
      test_boundaries();
      test_random();
      test_back_to_back();
      test_reset_mid_op();
      test_basic();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %0d leftover entries, want 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
